ps2_scan_rx: RTL and testbench
==============================

// Module: ps2_scan_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the key-mapping stage (direction, choose, pause and restart decode).
//  Samples the raw PS/2 clock and data lines in the system clock domain and deframes 11-bit frames.
//  Folds E0 (extended) and F0 (break) prefixes into flags.
//  Outputs a one-cycle scan-code event plus a held "current key" byte that is 0x00 when no key is down.
// PARAMETERS
//  FILT_LEN    4      consecutive equal synced samples needed to accept a PS/2 clock level change
//  TIMEOUT_CYC 100000 system cycles without a PS/2 falling edge mid-frame before the frame is aborted
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous active-high reset
//  clkin      in   1  raw PS/2 clock (async, open-drain)
//  datain     in   1  raw PS/2 data (async, open-drain)
//  data       out  8  held scan code of the last make; 0x00 once that key is released
//  code       out  8  scan code of the last completed event
//  code_valid out  1  one-cycle pulse: code/is_break/is_ext are valid
//  is_break   out  1  event was preceded by F0
//  is_ext     out  1  event was preceded by E0
//  frame_err  out  1  one-cycle pulse on a bad start/stop bit, a bad parity or a timeout
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; prefix flags cleared; filter state=1; timeout counter 0.
//  - Input sync: clkin and datain each pass through a 2-FF synchroniser.
//  - Clock filter: the filtered clock changes only after FILT_LEN equal synced samples.
//  - Edge detect: fall = filtered clock goes 1->0. datain_sync is sampled on that cycle.
//  - FSM states:
//    - IDLE: on fall with data==0 -> DATA, bit count 0. On fall with data==1 -> frame_err, stay IDLE.
//    - DATA: 8 falls, LSB first into a shift register. After the 8th -> PARITY.
//    - PARITY: on fall, latch the parity bit -> STOP.
//    - STOP: on fall, check the stop bit (must be 1), then -> IDLE.
//  - Byte accept: a frame is accepted if the stop bit is 1 and {byte, parity} has odd weight.
//    - Otherwise: frame_err pulses the cycle after the stop fall, the byte is dropped, and the flags are kept.
//  - Byte decode for an accepted byte:
//    - 0xE0 sets ext. 0xF0 sets brk. Neither produces an event.
//    - Any other byte: the cycle after the stop fall, code=byte, is_break=brk, is_ext=ext, and code_valid=1 for exactly one cycle.
//    - ext and brk then clear.
//  - Latency: code_valid appears 1 clk after the cycle the stop-bit fall is detected.
//    - That is 2 (sync) + FILT_LEN + 1 clks after the raw clkin falls.
//  - code, is_break and is_ext hold until the next event.
//  - data update:
//    - On a make event: data <= code.
//    - On a break event whose code == data: data <= 0x00.
//    - On a break for another key: data unchanged.
//  - Timeout: the counter runs while FSM != IDLE and clears on every fall.
//    - When it reaches TIMEOUT_CYC-1: FSM -> IDLE, frame_err pulses, and the ext/brk flags clear.
//  - rst in any state (including mid-frame) returns to the reset state next cycle.
//    - The partial frame is discarded and no event or error is emitted.
//  - Simultaneous fall and timeout in the same cycle: the fall wins and the counter clears.
//  - Prefix sequences:
//    - E0 F0 xx gives is_ext=1 and is_break=1.
//    - Repeated F0 F0 is the same as one F0.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: parity is checked as above.
//  Not defined: the parity bit is ignored, and only the stop bit gates acceptance and frame_err.
// TESTING
//  - Frame 0x1D (start 0, 1D LSB first, parity 1, stop 1) -> code_valid 1 cycle, code=1D, is_break=0, is_ext=0, data=1D.
//  - Frames F0 then 1D after the previous test -> one code_valid with code=1D, is_break=1; data=00; no pulse for F0.
//  - Frames E0,75 then E0,F0,75 -> events (75,ext=1,brk=0) and (75,ext=1,brk=1); data 75 then 00.
//  - 0x1D with parity 0:
//    - PARITY_CHECK_EN on -> frame_err pulse, no code_valid, data unchanged.
//    - Off -> normal event.
//  - Stop after 5 data bits, idle TIMEOUT_CYC clks -> one frame_err; the next good frame 0x1C decodes as 1C.
//  - 2-cycle low glitch on clkin with FILT_LEN=4 -> no bit shifted; rst mid-DATA -> outputs 0, next frame decodes correctly.

Source files
------------

// File: rtl/ps2_scan_if.sv
// PS/2 receiver bus: raw PS/2 line inputs plus the decoded scan-code event outputs.
// master = receiver side (samples the lines, drives the event); slave = line driver / key-mapping consumer.
interface ps2_scan_if;
  logic       clkin;
  logic       datain;
  logic [7:0] data;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_ext;
  logic       frame_err;

  modport master (
    input  clkin, datain,
    output data, code, code_valid, is_break, is_ext, frame_err
  );

  modport slave (
    output clkin, datain,
    input  data, code, code_valid, is_break, is_ext, frame_err
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and debounces the PS/2 clock, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and emits a one-cycle scan-code event plus a held "current key".
// Optional feature macro: PS2_PARITY_CHECK_EN (defined: odd parity gates acceptance;
// undefined: the parity bit is ignored and only the stop bit gates acceptance).
module ps2_scan_rx #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  ps2_scan_if.master bus
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_prev;
  logic          fall;

  state_t        state_q, state_n;
  logic [2:0]    bit_cnt_q, bit_cnt_n;
  logic [7:0]    shift_q, shift_n;
  logic          ext_q, ext_n, brk_q, brk_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic [7:0]    data_q, data_n, code_q, code_n;
  logic          valid_q, valid_n, isbrk_q, isbrk_n, isext_q, isext_n, err_q, err_n;
  logic          accept;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_n;
`endif

  // Two-flop synchronisers on both lines, then a level filter on the PS/2 clock
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_s1    <= bus.clkin;
      clk_s2    <= clk_s1;
      dat_s1    <= bus.datain;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Frame FSM register plus decoded outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      isbrk_q   <= 1'b0;
      isext_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
      ext_q     <= ext_n;
      brk_q     <= brk_n;
      tmo_q     <= tmo_n;
      data_q    <= data_n;
      code_q    <= code_n;
      valid_q   <= valid_n;
      isbrk_q   <= isbrk_n;
      isext_q   <= isext_n;
      err_q     <= err_n;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_n;
`endif
    end
  end

  // Next-state: deframing on filtered falls, mid-frame timeout, prefix folding and key tracking
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shift_n   = shift_q;
    ext_n     = ext_q;
    brk_n     = brk_q;
    tmo_n     = tmo_q;
    data_n    = data_q;
    code_n    = code_q;
    isbrk_n   = isbrk_q;
    isext_n   = isext_q;
    valid_n   = 1'b0;
    err_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n     = par_q;
    accept    = dat_s2 & (^{shift_q, par_q});
`else
    accept    = dat_s2;
`endif

    // A fall in the same cycle as expiry wins: the counter clears and the frame continues.
    if (state_q != IDLE) begin
      if (fall) begin
        tmo_n = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_n = IDLE;
        err_n   = 1'b1;
        ext_n   = 1'b0;
        brk_n   = 1'b0;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo_q + TW'(1);
      end
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (dat_s2) begin
            err_n = 1'b1;
          end else begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n   = {dat_s2, shift_q[7:1]};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_n = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_n   = dat_s2;
`endif
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!accept) begin
            err_n = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_n = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_n = 1'b1;
          end else begin
            code_n  = shift_q;
            isbrk_n = brk_q;
            isext_n = ext_q;
            valid_n = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
            if (!brk_q)                data_n = shift_q;
            else if (shift_q == data_q) data_n = 8'h00;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.code       = code_q;
  assign bus.code_valid = valid_q;
  assign bus.is_break   = isbrk_q;
  assign bus.is_ext     = isext_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed vector table, hand-written corner sequences
// (glitch, idle error, timeout, mid-frame reset) and randomized frames against a behavioural model.
module tb_ps2_scan_rx;

  localparam int FILT = 4;
  localparam int TMO  = 300;
  localparam int H    = 10;            // half period of the emulated PS/2 clock, in system clocks
  localparam int LAT  = 2 + FILT + 1;  // raw clkin fall to code_valid / frame_err

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_valid;
    ev_t        exp_ev;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scan_if bus ();

  ps2_scan_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Monitor: record every event and error pulse seen outside reset
  ev_t obs_q[$];
  int  err_seen = 0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.code_valid) obs_q.push_back({bus.code, bus.is_break, bus.is_ext});
      if (bus.frame_err)  err_seen++;
    end
  end

  // Behavioural model state
  logic       m_ext, m_brk;
  logic [7:0] m_data;
  ev_t        last_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [7:0] b, bit bp, bit bs, bit v, logic [7:0] c,
                              bit brk, bit ext, bit err, logic [7:0] d);
    vec_t r;
    r.b = b; r.bad_par = bp; r.bad_stop = bs; r.exp_valid = v;
    r.exp_ev = {c, brk, ext}; r.exp_err = err; r.exp_data = d;
    return r;
  endfunction

  // One PS/2 bit: high phase with data set up, then low phase; reports pulse latency after the fall
  task automatic drive_bit(input logic v, input bit glitch, output int lat);
    lat = 0;
    bus.datain = v;
    bus.clkin  = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk);
      bus.clkin = 1'b0;
      repeat (2) @(negedge clk);
      bus.clkin = 1'b1;
      repeat (H - 5) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    bus.clkin = 1'b0;
    for (int i = 1; i <= H; i++) begin
      @(negedge clk);
      if (lat == 0 && (bus.code_valid || bus.frame_err)) lat = i;
    end
  endtask

  task automatic line_idle(input int n);
    bus.clkin  = 1'b1;
    bus.datain = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input bit glitch,
                            output int lat);
    logic [10:0] bits;
    int l;
    bits = {~bs, (~^b) ^ bp, b, 1'b0};
    l = 0;
    for (int i = 0; i < 11; i++) drive_bit(bits[i], glitch, l);
    lat = l;
    line_idle(15);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs,
                           input bit glitch, input bit exp_valid, input ev_t exp_ev,
                           input bit exp_err, input logic [7:0] exp_data);
    int lat, base_err, base_obs;
    base_err = err_seen;
    base_obs = obs_q.size();
    send_frame(b, bp, bs, glitch, lat);
    if (exp_valid) last_ev = exp_ev;
    check({tag, " events"}, obs_q.size() - base_obs, exp_valid);
    if (exp_valid && obs_q.size() > base_obs) check({tag, " event"}, obs_q[base_obs], exp_ev);
    check({tag, " frame_err"}, err_seen - base_err, exp_err);
    check({tag, " data"}, bus.data, exp_data);
    check({tag, " held"}, {bus.code, bus.is_break, bus.is_ext}, last_ev);
    if (exp_valid || exp_err) check({tag, " latency"}, lat, LAT);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs,
                             output bit v, output ev_t e, output bit err);
    bit ok;
`ifdef PS2_PARITY_CHECK_EN
    ok = !bs && !bp;
`else
    ok = !bs;
`endif
    v = 1'b0;
    e = '0;
    err = !ok;
    if (ok) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        v = 1'b1;
        e = {b, m_brk, m_ext};
        if (!m_brk) m_data = b;
        else if (b == m_data) m_data = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    bit   ck;
    int   lat, base_err, base_obs;
    logic [7:0] pb;

`ifdef PS2_PARITY_CHECK_EN
    ck = 1'b1;
`else
    ck = 1'b0;
`endif
    last_ev = '0;

    // Directed table: prefixes, make/break tracking, parity and stop errors
    tbl.push_back(mk(8'h1D, 0, 0, 1, 8'h1D, 0, 0, 0, 8'h1D));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h1D));
    tbl.push_back(mk(8'h1D, 0, 0, 1, 8'h1D, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h75, 0, 0, 1, 8'h75, 0, 1, 0, 8'h75));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h75));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h75));
    tbl.push_back(mk(8'h75, 0, 0, 1, 8'h75, 1, 1, 0, 8'h00));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 8'h1C));
    tbl.push_back(mk(8'h1D, 1, 0, !ck, 8'h1D, 0, 0, ck, ck ? 8'h1C : 8'h1D));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, ck ? 8'h1C : 8'h1D));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, ck ? 8'h1C : 8'h1D));
    tbl.push_back(mk(8'h1D, 0, 0, 1, 8'h1D, 1, 0, 0, ck ? 8'h1C : 8'h00));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, ck ? 8'h1C : 8'h00));
    tbl.push_back(mk(8'h33, 0, 1, 0, 8'h00, 0, 0, 1, ck ? 8'h1C : 8'h00));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'h5A, 0, 0, 1, 8'h5A, 0, 0, 0, 8'h5A));

    // Reset state
    rst = 1'b1;
    bus.clkin  = 1'b1;
    bus.datain = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus.data, bus.code, bus.code_valid, bus.is_break, bus.is_ext, bus.frame_err}, '0);
    rst = 1'b0;
    line_idle(10);

    for (int i = 0; i < tbl.size(); i++)
      run_frame($sformatf("vec%0d", i), tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, 1'b0,
                tbl[i].exp_valid, tbl[i].exp_ev, tbl[i].exp_err, tbl[i].exp_data);

    // Short clkin glitches in every high phase must not shift extra bits
    run_frame("glitch", 8'h29, 0, 0, 1, 1, {8'h29, 1'b0, 1'b0}, 0, 8'h29);

    // A fall with data high while idle is a bad start bit
    base_err = err_seen;
    base_obs = obs_q.size();
    drive_bit(1'b1, 1'b0, lat);
    line_idle(15);
    check("bad start err", err_seen - base_err, 1);
    check("bad start events", obs_q.size() - base_obs, 0);
    check("bad start latency", lat, LAT);

    // Abandoned frame after 5 data bits times out and clears the pending break prefix
    run_frame("pre-timeout F0", 8'hF0, 0, 0, 0, 0, '0, 0, 8'h29);
    base_err = err_seen;
    base_obs = obs_q.size();
    pb = 8'h6B;
    drive_bit(1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) drive_bit(pb[i], 1'b0, lat);
    line_idle(TMO - 20);
    check("timeout early", err_seen - base_err, 0);
    line_idle(40);
    check("timeout err", err_seen - base_err, 1);
    check("timeout events", obs_q.size() - base_obs, 0);
    run_frame("after timeout", 8'h1C, 0, 0, 0, 1, {8'h1C, 1'b0, 1'b0}, 0, 8'h1C);

    // Reset mid-DATA discards the partial frame and the pending prefix
    run_frame("pre-reset F0", 8'hF0, 0, 0, 0, 0, '0, 0, 8'h1C);
    base_err = err_seen;
    base_obs = obs_q.size();
    drive_bit(1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) drive_bit(pb[i], 1'b0, lat);
    bus.clkin  = 1'b1;
    bus.datain = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid reset outputs", {bus.data, bus.code, bus.code_valid, bus.is_break, bus.is_ext, bus.frame_err}, '0);
    rst = 1'b0;
    line_idle(10);
    check("mid reset err", err_seen - base_err, 0);
    last_ev = '0;
    run_frame("after reset", 8'h1D, 0, 0, 0, 1, {8'h1D, 1'b0, 1'b0}, 0, 8'h1D);

    // Randomized frames against the behavioural model
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_data = 8'h1D;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit bp, bs, v, err;
      ev_t e;
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = (m_data != 8'h00) ? m_data : 8'(($urandom_range(1, 255)));
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      model_frame(b, bp, bs, v, e, err);
      run_frame($sformatf("rand%0d", i), b, bp, bs, 1'b0, v, e, err, m_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
